// File: rtl/reg_file_scoreboard_pkg.sv
// reg_file_scoreboard_pkg: shared register-file widths and index/data types for the pipeline stages
package reg_file_scoreboard_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 2;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_scoreboard_sb_counter.sv
// sb_counter: saturating up/down count of in-flight writers for one register
module sb_counter
  import reg_file_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt,
  output logic             error
);
  localparam logic [CNT_W:0] MAX = (CNT_W+1)'((1 << CNT_W) - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   up, net;
  logic [1:0]       dn;
  logic             under, over;
  // net of all three events in one step; clamp at 0 / max and flag the clamp
  always_comb begin
    up    = {1'b0, cnt_q} + (CNT_W+1)'(inc);
    dn    = 2'(dec_wb) + 2'(dec_kill);
    under = up < (CNT_W+1)'(dn);
    net   = up - (CNT_W+1)'(dn);
    over  = !under && net > MAX;
    cnt_d = under ? '0 : over ? MAX[CNT_W-1:0] : net[CNT_W-1:0];
    error = under || over;
  end
  // counter state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with WB bypass and per-register pending-writer scoreboard
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_idx_t  src1,
  input  reg_idx_t  src2,
  output reg_data_t reg1,
  output reg_data_t reg2,
  output logic      hazard1,
  output logic      hazard2,
  input  logic      issue_en,
  input  reg_idx_t  issue_dest,
  input  logic      kill_en,
  input  reg_idx_t  kill_dest,
  input  logic      WB_en,
  input  reg_idx_t  WB_Dest,
  input  reg_data_t WB_Value,
  output logic      sb_error
);
  reg_data_t        regs_q [1:NUM_REGS-1];
  reg_data_t        regs_d [1:NUM_REGS-1];
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] err;
  logic             sb_error_q, sb_error_d;
  logic             wb1, wb2;
  assign cnt[0] = '0;
  assign err[0] = 1'b0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (issue_en && issue_dest == ADDR_W'(g)),
      .dec_wb   (WB_en && WB_Dest == ADDR_W'(g)),
      .dec_kill (kill_en && kill_dest == ADDR_W'(g)),
      .cnt      (cnt[g]),
      .error    (err[g])
    );
  end
  // next array contents and sticky error
  always_comb begin
    regs_d = regs_q;
    if (WB_en && WB_Dest != '0) regs_d[WB_Dest] = WB_Value;
    sb_error_d = sb_error_q || (|err);
  end
  // register array and error flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      sb_error_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      sb_error_q <= sb_error_d;
    end
  // read ports with same-cycle WB bypass; a writer retiring now no longer counts as a hazard
  always_comb begin
    wb1     = WB_en && WB_Dest == src1;
    wb2     = WB_en && WB_Dest == src2;
    reg1    = (!rst_n || src1 == '0) ? '0 : wb1 ? WB_Value : regs_q[src1];
    reg2    = (!rst_n || src2 == '0) ? '0 : wb2 ? WB_Value : regs_q[src2];
    hazard1 = rst_n && src1 != '0 && cnt[src1] > CNT_W'(wb1);
    hazard2 = rst_n && src2 != '0 && cnt[src2] > CNT_W'(wb2);
  end
  assign sb_error = sb_error_q;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: table-driven checks of reads, bypass, hazards and scoreboard errors
module tb_reg_file_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  src1, src2, issue_dest, kill_dest, WB_Dest;
  logic        issue_en, kill_en, WB_en;
  logic [31:0] WB_Value, reg1, reg2;
  logic        hazard1, hazard2, sb_error;
  int          n_vec = 0, n_bad = 0;

  typedef struct {
    logic [4:0] s1, s2; logic ie; logic [4:0] id; logic ke; logic [4:0] kd;
    logic we; logic [4:0] wd; logic [31:0] wv;
    logic [31:0] r1, r2; logic h1, h2, er;
  } vec_t;
  typedef struct { logic [31:0] r1, r2; logic h1, h2, er; string nm; } exp_t;
  exp_t exp_q[$];
  vec_t tbl[$];

  reg_file_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
    .hazard1(hazard1), .hazard2(hazard2), .issue_en(issue_en), .issue_dest(issue_dest),
    .kill_en(kill_en), .kill_dest(kill_dest), .WB_en(WB_en), .WB_Dest(WB_Dest),
    .WB_Value(WB_Value), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [4:0] s1, s2, logic ie, logic [4:0] id, logic ke,
                              logic [4:0] kd, logic we, logic [4:0] wd, logic [31:0] wv,
                              logic [31:0] r1, r2, logic h1, h2, er);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.ie = ie; v.id = id; v.ke = ke; v.kd = kd;
    v.we = we; v.wd = wd; v.wv = wv; v.r1 = r1; v.r2 = r2; v.h1 = h1; v.h2 = h2; v.er = er;
    return v;
  endfunction

  task automatic idle();
    issue_en = 0; issue_dest = 0; kill_en = 0; kill_dest = 0;
    WB_en = 0; WB_Dest = 0; WB_Value = 0;
  endtask

  task automatic apply(vec_t v, string nm);
    src1 = v.s1; src2 = v.s2; issue_en = v.ie; issue_dest = v.id;
    kill_en = v.ke; kill_dest = v.kd; WB_en = v.we; WB_Dest = v.wd; WB_Value = v.wv;
    exp_q.push_back('{v.r1, v.r2, v.h1, v.h2, v.er, nm});
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check(bit at_neg);
    exp_t e;
    if (at_neg) @(negedge clk);
    else #1;
    e = exp_q.pop_front();
    cmp({e.nm, ".reg1"}, reg1, e.r1);
    cmp({e.nm, ".reg2"}, reg2, e.r2);
    cmp({e.nm, ".hazard1"}, 32'(hazard1), 32'(e.h1));
    cmp({e.nm, ".hazard2"}, 32'(hazard2), 32'(e.h2));
    cmp({e.nm, ".sb_error"}, 32'(sb_error), 32'(e.er));
  endtask

  task automatic step(vec_t v, string nm);
    @(posedge clk);
    #1 apply(v, nm);
    check(1);
  endtask

  initial begin
    //            s1 s2 ie id ke kd we wd wv            r1            r2         h1 h2 er
    tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0,            0,            0,           0, 0, 0));
    tbl.push_back(mk(7, 0, 1, 7, 0, 0, 0, 0, 0,            0,            0,           0, 0, 0));
    tbl.push_back(mk(7, 7, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(7, 3, 0, 0, 0, 0, 0, 0, 0,            32'hDEADBEEF, 0,           0, 0, 0));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 1, 0, 32'h1234,     0,            32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(3, 0, 1, 3, 0, 0, 0, 0, 0,            0,            0,           0, 0, 0));
    tbl.push_back(mk(3, 3, 1, 3, 0, 0, 0, 0, 0,            0,            0,           1, 1, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0,            0,            0,           1, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 1, 3, 32'h33,       32'h33,       0,           1, 0, 0));
    tbl.push_back(mk(3, 3, 0, 0, 0, 0, 1, 3, 32'h44,       32'h44,       32'h44,      0, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0,            32'h44,       0,           0, 0, 0));
    tbl.push_back(mk(9, 0, 1, 9, 0, 0, 0, 0, 0,            0,            0,           0, 0, 0));
    tbl.push_back(mk(9, 0, 1, 9, 0, 0, 0, 0, 0,            0,            0,           1, 0, 0));
    tbl.push_back(mk(9, 9, 1, 9, 1, 9, 1, 9, 32'h99,       32'h99,       32'h99,      1, 1, 0));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0,            32'h99,       0,           1, 0, 0));
    tbl.push_back(mk(9, 0, 0, 0, 1, 9, 0, 0, 0,            32'h99,       0,           1, 0, 0));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0,            32'h99,       0,           0, 0, 0));
    tbl.push_back(mk(4, 0, 1, 4, 0, 0, 0, 0, 0,            0,            0,           0, 0, 0));
    tbl.push_back(mk(4, 0, 1, 4, 0, 0, 0, 0, 0,            0,            0,           1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 4, 0, 0, 0, 0, 0,            0,            0,           1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 4, 0, 0, 0, 0, 0,            0,            0,           1, 0, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 0,            0,            0,           1, 0, 1));
    tbl.push_back(mk(10, 0, 0, 0, 0, 0, 1, 10, 32'hA,      32'hA,        0,           0, 0, 1));
    tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0,           32'hA,        0,           0, 0, 1));
    tbl.push_back(mk(4, 4, 0, 0, 0, 0, 1, 4, 32'h4,        32'h4,        32'h4,       1, 1, 1));

    rst_n = 1'b0; src1 = 0; src2 = 0; idle();
    @(posedge clk);
    #1 apply(mk(5, 5, 1, 5, 0, 0, 1, 5, 32'h55, 0, 0, 0, 0, 0), "in_reset");
    check(1);
    idle();
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    @(posedge clk);
    #1 apply(mk(10, 0, 0, 0, 0, 0, 1, 10, 32'h5, 32'h5, 0, 0, 0, 1), "pre_rst");
    check(1);
    #2 rst_n = 1'b0;
    exp_q.push_back('{32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "async_rst"});
    check(0);
    idle();
    rst_n = 1'b1;
    step(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "after_rst");

    @(posedge clk);
    #1 apply(mk(12, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "issue12");
    check(1);
    #1 rst_n = 1'b0;
    idle();
    #1 rst_n = 1'b1;
    step(mk(12, 12, 0, 0, 0, 0, 1, 12, 32'hC, 32'hC, 32'hC, 0, 0, 0), "wb12_forgot");
    step(mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0, 0, 0, 1), "underflow12");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
